// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - iterative IEEE-754 single-precision divider, one quotient bit per cycle
//
// Truncating (round-toward-zero) single-precision divide behind a valid/ready
// handshake with a pass-through reservation-station tag.
//
// Optional feature macro: FP_DIV_DENORM_EN
//   defined   : denormal inputs are normalized in PRENORM, denormal results produced
//   undefined : E==0 inputs are treated as signed zero, results with exp <= 0 flush to zero
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               synchronous abort of the in-flight operation
//   in_valid/in_ready   operand handshake; in_a dividend, in_b divisor, in_tag tag
//   out_valid/out_ready result handshake; out_data quotient, out_tag tag of the result
module fp_div_seq #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRENORM = 3'd1;
    localparam logic [2:0] S_DIV     = 3'd2;
    localparam logic [2:0] S_PACK    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]        state;
    logic [23:0]       ma, mb;
    logic signed [9:0] ea, eb;
    logic              sign;
    logic [25:0]       rem;
    logic [24:0]       quo;
    logic [4:0]        cnt;

    // One restoring-division step: {quotient bit, shifted partial remainder}.
    // After a subtract the remainder is below the divisor (< 2^24), so the
    // shifted value always fits in 26 bits.
    function automatic logic [26:0] div_step(input logic [25:0] r, input logic [23:0] d);
        logic        q;
        logic [25:0] t;
        q = (r >= {2'b00, d});
        t = q ? (r - {2'b00, d}) : r;
        return {q, t[24:0], 1'b0};
    endfunction

    // ---------------- operand decode ----------------
    logic [7:0]        exa, exb;
    logic [23:0]       ma_in, mb_in;
    logic signed [9:0] ea_in, eb_in;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic              is_special;
    logic [31:0]       special_data;
    logic              res_sign;

    always_comb begin
        exa      = in_a[30:23];
        exb      = in_b[30:23];
        ma_in    = {exa != 8'd0, in_a[22:0]};
        mb_in    = {exb != 8'd0, in_b[22:0]};
        ea_in    = (exa == 8'd0) ? 10'sd1 : $signed({2'b00, exa});
        eb_in    = (exb == 8'd0) ? 10'sd1 : $signed({2'b00, exb});
        res_sign = in_a[31] ^ in_b[31];
`ifdef FP_DIV_DENORM_EN
        a_zero   = (exa == 8'd0) && (in_a[22:0] == 23'd0);
        b_zero   = (exb == 8'd0) && (in_b[22:0] == 23'd0);
`else
        a_zero   = (exa == 8'd0);
        b_zero   = (exb == 8'd0);
`endif
        a_inf    = (exa == 8'hFF) && (in_a[22:0] == 23'd0);
        b_inf    = (exb == 8'hFF) && (in_b[22:0] == 23'd0);
        a_nan    = (exa == 8'hFF) && (in_a[22:0] != 23'd0);
        b_nan    = (exb == 8'hFF) && (in_b[22:0] != 23'd0);

        is_special   = 1'b1;
        special_data = {res_sign, 31'd0};
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
            special_data = 32'hFFFF_FFFF;
        else if ((b_zero && !a_zero) || (a_inf && !b_inf))
            special_data = {res_sign, 8'hFF, 23'd0};
        else if (a_zero || b_inf)
            special_data = {res_sign, 31'd0};
        else
            is_special = 1'b0;
    end

    // Quotient bit for the edge entering DIV, from raw (non-prenorm) operands.
    logic [26:0] step_in;
    assign step_in = div_step({2'b00, ma_in}, mb_in);

    // Iterative step on the registered remainder.
    logic [26:0] step_div;
    assign step_div = div_step(rem, mb);

`ifdef FP_DIV_DENORM_EN
    // PRENORM: shift any unnormalized significand by one; the edge that
    // leaves both normalized also produces the first quotient bit.
    logic [23:0]       na, nb;
    logic signed [9:0] nea, neb;
    logic [26:0]       step_pre;
    always_comb begin
        na  = ma[23] ? ma : {ma[22:0], 1'b0};
        nb  = mb[23] ? mb : {mb[22:0], 1'b0};
        nea = ma[23] ? ea : (ea - 10'sd1);
        neb = mb[23] ? eb : (eb - 10'sd1);
    end
    assign step_pre = div_step({2'b00, na}, nb);
`endif

    // ---------------- pack ----------------
    logic [23:0]       sig;
    logic signed [9:0] exp_r;
    logic [31:0]       pack_data;
`ifdef FP_DIV_DENORM_EN
    logic [9:0]        shamt;
    logic [23:0]       den;
`endif

    always_comb begin
        sig       = quo[24] ? quo[24:1] : quo[23:0];
        exp_r     = ea - eb + (quo[24] ? 10'sd127 : 10'sd126);
        pack_data = {sign, 31'd0};
`ifdef FP_DIV_DENORM_EN
        shamt     = 10'd1 - exp_r;
        den       = sig >> shamt[4:0];
`endif
        if (exp_r >= 10'sd255)
            pack_data = {sign, 8'hFF, 23'd0};
        else if (exp_r > 10'sd0)
            pack_data = {sign, exp_r[7:0], sig[22:0]};
`ifdef FP_DIV_DENORM_EN
        else if (shamt < 10'd24)
            pack_data = {sign, 8'h00, den[22:0]};
`endif
    end

    // ---------------- control ----------------
    logic accept;
    assign in_ready  = rst_n && (state == S_IDLE) && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ma       <= 24'd0;
            mb       <= 24'd0;
            ea       <= 10'sd0;
            eb       <= 10'sd0;
            sign     <= 1'b0;
            rem      <= 26'd0;
            quo      <= 25'd0;
            cnt      <= 5'd0;
            out_data <= 32'd0;
            out_tag  <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        out_tag <= in_tag;
                        sign    <= res_sign;
                        ma      <= ma_in;
                        mb      <= mb_in;
                        ea      <= ea_in;
                        eb      <= eb_in;
                        cnt     <= 5'd0;
                        if (is_special) begin
                            out_data <= special_data;
                            state    <= S_DONE;
                        end else begin
`ifdef FP_DIV_DENORM_EN
                            state <= S_PRENORM;
`else
                            rem   <= step_in[25:0];
                            quo   <= {24'd0, step_in[26]};
                            state <= S_DIV;
`endif
                        end
                    end
                end
`ifdef FP_DIV_DENORM_EN
                S_PRENORM: begin
                    ma <= na;
                    mb <= nb;
                    ea <= nea;
                    eb <= neb;
                    if (na[23] && nb[23]) begin
                        rem   <= step_pre[25:0];
                        quo   <= {24'd0, step_pre[26]};
                        state <= S_DIV;
                    end
                end
`endif
                S_DIV: begin
                    rem <= step_div[25:0];
                    quo <= {quo[23:0], step_div[26]};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd23)
                        state <= S_PACK;
                end
                S_PACK: begin
                    out_data <= pack_data;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // step_in only feeds the datapath when PRENORM is compiled out.
`ifdef FP_DIV_DENORM_EN
    logic unused_step_in;
    assign unused_step_in = ^step_in;
`endif

endmodule

// File: tb/tb_fp_div_seq.sv
// tb/tb_fp_div_seq.sv - directed self-checking bench for fp_div_seq
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic [3:0]  in_tag = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_tag;

    int checks = 0;
    int errors = 0;

`ifdef FP_DIV_DENORM_EN
    localparam int LAT_N   = 27;
    localparam int LAT_DEN = 49;
    localparam logic [31:0] UF_RES  = 32'h0040_0000;
    localparam logic [31:0] DEN_RES = 32'h3F80_0000;
`else
    localparam int LAT_N   = 26;
    localparam int LAT_DEN = 1;
    localparam logic [31:0] UF_RES  = 32'h0000_0000;
    localparam logic [31:0] DEN_RES = 32'hFFFF_FFFF;
`endif

    always #5 clk = ~clk;

    fp_div_seq #(.TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", name, obs, exp);
        end
    endtask

    // Present one operation, measure edges from the accept edge to out_valid.
    // Result is left pending (out_ready=0) for the caller to retire.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                         output int lat);
        @(negedge clk);
        in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic retire();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] t, input logic [31:0] exp_d, input int exp_lat);
        int lat;
        issue(a, b, t, lat);
        check({name, " latency"}, lat, exp_lat);
        check({name, " data"}, out_data, exp_d);
        check({name, " tag"}, {28'd0, out_tag}, {28'd0, t});
        retire();
        check({name, " retired"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int lat;
        int rises;
        logic [31:0] held;

        // reset state
        #2;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_data", out_data, 32'd0);
        check("reset out_tag", {28'd0, out_tag}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready after reset", {31'd0, in_ready}, 32'd1);

        // main function
        run_op("6/2",  32'h40C0_0000, 32'h4000_0000, 4'd5, 32'h4040_0000, LAT_N);
        run_op("1/3",  32'h3F80_0000, 32'h4040_0000, 4'd9, 32'h3EAA_AAAA, LAT_N);
        run_op("-3/0.5", 32'hC040_0000, 32'h3F00_0000, 4'd2, 32'hC0C0_0000, LAT_N);

        // specials
        run_op("1/0",   32'h3F80_0000, 32'h0000_0000, 4'd1, 32'h7F80_0000, 1);
        run_op("0/0",   32'h0000_0000, 32'h0000_0000, 4'd3, 32'hFFFF_FFFF, 1);
        run_op("-inf/2", 32'hFF80_0000, 32'h4000_0000, 4'd4, 32'hFF80_0000, 1);
        run_op("nan/1", 32'h7FC0_0000, 32'h3F80_0000, 4'd6, 32'hFFFF_FFFF, 1);
        run_op("2/-inf", 32'h4000_0000, 32'hFF80_0000, 4'd7, 32'h8000_0000, 1);

        // range limits
        run_op("overflow",  32'h7F00_0000, 32'h3E80_0000, 4'd8, 32'h7F80_0000, LAT_N);
        run_op("underflow", 32'h0080_0000, 32'h4000_0000, 4'd10, UF_RES, LAT_N);
        run_op("denorm",    32'h0000_0001, 32'h0000_0001, 4'd11, DEN_RES, LAT_DEN);

        // back-pressure: result held stable, no accept while pending
        issue(32'h40C0_0000, 32'h4000_0000, 4'd12, lat);
        check("hold latency", lat, LAT_N);
        held = out_data;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold data", out_data, 32'h4040_0000);
            check("hold in_ready", {31'd0, in_ready}, 32'd0);
        end
        check("hold data vs first", out_data, held);
        retire();
        check("release in_ready", {31'd0, in_ready}, 32'd1);
        check("release out_valid", {31'd0, out_valid}, 32'd0);

        // flush mid-DIV
        @(negedge clk);
        in_a = 32'h40C0_0000; in_b = 32'h4000_0000; in_tag = 4'd13; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        check("flush blocks in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        check("in_ready after flush", {31'd0, in_ready}, 32'd1);
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) rises++;
        end
        check("no result after flush", rises, 0);

        // flush together with in_valid: no accept
        @(negedge clk);
        in_a = 32'h3F80_0000; in_b = 32'h0000_0000; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush+valid no accept", {31'd0, out_valid}, 32'd0);

        // reset mid-DIV
        @(negedge clk);
        in_a = 32'h40C0_0000; in_b = 32'h4000_0000; in_tag = 4'd14; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst out_data", out_data, 32'd0);
        check("rst out_tag", {28'd0, out_tag}, 32'd0);
        check("rst in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready after rst", {31'd0, in_ready}, 32'd1);
        run_op("after rst", 32'h4100_0000, 32'h4080_0000, 4'd15, 32'h4000_0000, LAT_N);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fp_div_seq.md
# fp_div_seq

Iterative IEEE-754 single-precision divider producing one quotient bit per cycle. It is the divide-side companion to the combinational floating-point multiplier in the FP functional-unit cluster. It sits behind a reservation station, accepting one operation at a time with a valid/ready handshake and a pass-through tag. Results are truncated (round-toward-zero), which matches the multiplier.

## Interface
- TAG_W, 4: width of reservation-station tag carried from input to output
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of the in-flight operation
- in_valid  in  1  operands presented
- in_ready  out  1  high only in IDLE and when flush=0
- in_a  in  32  dividend
- in_b  in  32  divisor
- in_tag  in  TAG_W  tag
- out_valid  out  1  result held until accepted
- out_ready  in  1  consumer accepts
- out_data  out  32  quotient
- out_tag  out  TAG_W  tag of the result

## Operation
- States: IDLE, PRENORM, DIV, PACK, DONE.
- Accept condition: in_valid && in_ready. On accept, split each operand into sign, exponent and fraction.
  - Significand M = {E!=0, frac}, 24 bits.
  - Effective exponent = (E==0) ? 1 : E, held signed in 10 bits.
  - Result sign = Sa ^ Sb.
- Special cases, IDLE→DONE directly:
  - NaN operand, 0/0, or inf/inf → 32'hFFFFFFFF.
  - Nonzero/0, or inf/finite → {s, 8'hFF, 23'b0}.
  - 0/nonzero, or finite/inf → {s, 31'b0}.
- Otherwise, accept → PRENORM (denormal support compiled in, see Configuration) or → DIV.
- PRENORM: each cycle, every significand with M[23]=0 shifts left 1 and its exponent decrements. Exit to DIV when both have M[23]=1. Minimum 1 cycle.
- DIV: restoring division, 25 cycles, producing Q[24:0] = Ma/Mb with Q[24] as the integer bit. Partial remainder is 26 bits.
- PACK (1 cycle):
  - If Q[24]=1: sig = Q[24:1], exp = Ea−Eb+127.
  - Else: sig = Q[23:0], exp = Ea−Eb+126.
  - exp ≥ 255 → signed inf.
  - exp ≤ 0 → frac = (sig >> (1−exp))[22:0], exp field 0. A shift of 24 or more gives signed zero.
  - Otherwise {s, exp[7:0], sig[22:0]}.
- DONE: out_valid=1. On out_valid && out_ready → IDLE, out_valid=0.
- flush (any state): → IDLE next edge, out_valid=0, no result emitted. flush together with in_valid: no accept.
- out_data and out_tag remain stable while out_valid=1.

## Timing
- Reset: state IDLE, out_valid=0, out_data=0, out_tag=0. in_ready becomes 1 once rst_n deasserts. Reset mid-operation discards the operation.
- Latency counts clock edges from the accept edge to out_valid=1:
  - Special case: 1.
  - Normal operands: 27 with the macro, 26 without.
  - Denormal operands: 25 + 1 + max(1, max leading-zero count).
- No accept while busy. Back-to-back throughput is one operation per (latency + 1) cycles minimum, because DONE→IDLE consumes the handshake edge.

## Configuration
- FP_DIV_DENORM_EN defined:
  - PRENORM present.
  - Denormal inputs are normalized.
  - Denormal results are produced per PACK.
- Undefined:
  - PRENORM removed.
  - Inputs with E==0 are treated as signed zero, so special-case rules apply.
  - Results with exp ≤ 0 flush to signed zero.

## Test plan
- 0x40C00000 / 0x40000000 (6/2), tag 5 → out_data 0x40400000, out_tag 5, out_valid 27 edges after accept (26 without macro).
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAA (truncated, not 0x3EAAAAAB).
- 1-cycle specials:
  - 0x3F800000 / 0x00000000 → 0x7F800000
  - 0x00000000 / 0x00000000 → 0xFFFFFFFF
  - 0xFF800000 / 0x40000000 → 0xFF800000
- Range limits:
  - Overflow 0x7F000000 / 0x3E800000 → 0x7F800000.
  - Underflow 0x00800000 / 0x40000000 → 0x00400000 with macro, 0x00000000 without.
- Denormals: 0x00000001 / 0x00000001 → 0x3F800000 at latency 49 with macro; 0xFFFFFFFF at latency 1 without.
- Handshake:
  - Hold out_ready=0 for 10 cycles → out_data stable, in_ready=0; release → in_ready=1 next cycle.
  - Assert flush mid-DIV → out_valid never rises, in_ready=1 next cycle.
  - Assert rst_n=0 mid-DIV → all outputs 0 immediately.
